// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// program_sequencer : program counter with INC/JUMP/BRANCH/CALL/RET and a
// LIFO return-address stack, sticky overflow/underflow error. Rev 1.0
// ============================================================================
module program_sequencer #(
  parameter int               WIDTH        = 16,
  parameter int               STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             error
);

  localparam int c_CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int c_PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(STACK_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [WIDTH-1:0]   c_PC_ONE  = WIDTH'(1);

  localparam logic [2:0] c_OP_INC    = 3'b000;
  localparam logic [2:0] c_OP_JUMP   = 3'b001;
  localparam logic [2:0] c_OP_BRANCH = 3'b010;
  localparam logic [2:0] c_OP_CALL   = 3'b011;
  localparam logic [2:0] c_OP_RET    = 3'b100;

  logic [WIDTH-1:0]   r_stack [STACK_DEPTH];
  logic [WIDTH-1:0]   r_pc;
  logic [c_CNT_W-1:0] r_count;
  logic               r_error;

  logic [WIDTH-1:0]   w_pc_inc;
  logic [WIDTH-1:0]   w_pc_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_err_nxt;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [c_PTR_W-1:0] w_push_idx;
  logic [c_PTR_W-1:0] w_top_idx;

  assign w_full     = (r_count == c_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_pc_inc   = r_pc + c_PC_ONE;
  assign w_push_idx = c_PTR_W'(r_count);
  assign w_top_idx  = c_PTR_W'(r_count - c_CNT_ONE);

  always_comb begin
    w_pc_nxt  = r_pc;
    w_cnt_nxt = r_count;
    w_err_nxt = r_error;
    w_push    = 1'b0;
    if (CE) begin
      case (op)
        c_OP_INC:    w_pc_nxt = w_pc_inc;
        c_OP_JUMP:   w_pc_nxt = IN;
        // Unsigned add is identical to a signed offset modulo 2^WIDTH.
        c_OP_BRANCH: w_pc_nxt = r_pc + IN;
        c_OP_CALL: begin
          if (w_full) begin
            w_err_nxt = 1'b1;
          end else begin
            w_push    = 1'b1;
            w_cnt_nxt = r_count + c_CNT_ONE;
            w_pc_nxt  = IN;
          end
        end
        c_OP_RET: begin
          if (w_empty) begin
            w_err_nxt = 1'b1;
          end else begin
            w_pc_nxt  = r_stack[w_top_idx];
            w_cnt_nxt = r_count - c_CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_VECTOR;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_count <= w_cnt_nxt;
      r_error <= w_err_nxt;
    end
  end

  // Stack storage needs no reset: entries above the occupancy are never read.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign OUT         = r_pc;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// tb_program_sequencer : directed + randomized steps checked against a
// queue-based reference model of the sequencer.
module tb_program_sequencer;

  localparam int          c_DEPTH = 8;
  localparam logic [15:0] c_RV    = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, CE;
  logic [2:0]  op;
  logic [15:0] IN;
  logic [15:0] OUT;
  logic        stack_full, stack_empty, error;

  program_sequencer #(
    .WIDTH       (16),
    .STACK_DEPTH (c_DEPTH),
    .RESET_VECTOR(c_RV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .CE         (CE),
    .op         (op),
    .IN         (IN),
    .OUT        (OUT),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] m_pc;
  logic        m_err;
  logic [15:0] m_stack[$];
  logic [15:0] ret_addrs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic ce, input logic [2:0] o,
                      input logic [15:0] d, input string tag);
    logic [15:0] nxt;
    rst = r; CE = ce; op = o; IN = d;
    if (r) begin
      m_pc = c_RV;
      m_stack.delete();
      m_err = 1'b0;
    end else if (ce) begin
      case (o)
        3'd0: m_pc = m_pc + 16'd1;
        3'd1: m_pc = d;
        3'd2: m_pc = m_pc + d;
        3'd3: begin
          if (m_stack.size() == c_DEPTH) m_err = 1'b1;
          else begin
            nxt = m_pc + 16'd1;
            m_stack.push_back(nxt);
            m_pc = d;
          end
        end
        3'd4: begin
          if (m_stack.size() == 0) m_err = 1'b1;
          else m_pc = m_stack.pop_back();
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    chk({tag, "/OUT"},   32'(OUT),         32'(m_pc));
    chk({tag, "/full"},  32'(stack_full),  32'(m_stack.size() == c_DEPTH));
    chk({tag, "/empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    chk({tag, "/error"}, 32'(error),       32'(m_err));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [15:0] rin;
    rst = 1'b1; CE = 1'b0; op = 3'd0; IN = '0;
    m_pc = c_RV; m_err = 1'b0;
    @(posedge clk); #1;

    step(1, 0, 3'd0, 16'h0, "reset");
    chk("reset_literal_OUT", 32'(OUT), 32'(c_RV));

    // INC x3 then hold with CE low
    step(0, 1, 3'd0, 16'h0, "inc1");
    step(0, 1, 3'd0, 16'h0, "inc2");
    step(0, 1, 3'd0, 16'h0, "inc3");
    chk("inc_literal", 32'(OUT), 32'h3);
    step(0, 0, 3'd1, 16'hAAAA, "ce_low1");
    step(0, 0, 3'd3, 16'h5555, "ce_low2");
    chk("ce_hold_literal", 32'(OUT), 32'h3);

    // Negative branch and wraparound
    step(0, 1, 3'd1, 16'h0010, "jmp10");
    step(0, 1, 3'd2, 16'hFFFE, "br_neg");
    chk("br_neg_literal", 32'(OUT), 32'h000E);
    step(0, 1, 3'd1, 16'hFFFF, "jmpffff");
    step(0, 1, 3'd0, 16'h0, "inc_wrap");
    chk("wrap_literal", 32'(OUT), 32'h0000);

    // Single call/return, plus HOLD and reserved ops
    step(0, 1, 3'd1, 16'h0005, "jmp5");
    step(0, 1, 3'd3, 16'h0100, "call1");
    step(0, 1, 3'd5, 16'h1234, "hold");
    step(0, 1, 3'd6, 16'h1234, "rsv6");
    step(0, 1, 3'd7, 16'h1234, "rsv7");
    step(0, 1, 3'd4, 16'h0, "ret1");
    chk("ret_literal", 32'(OUT), 32'h0006);

    // Fill the stack, overflow, then unwind in reverse order
    ret_addrs.delete();
    for (int i = 0; i < c_DEPTH; i++) begin
      ret_addrs.push_back(m_pc + 16'd1);
      step(0, 1, 3'd3, 16'(16'h0200 + i * 16'h10), "nest_call");
    end
    chk("full_after_8", 32'(stack_full), 32'h1);
    step(0, 1, 3'd3, 16'h0BAD, "overflow");
    chk("overflow_err", 32'(error), 32'h1);
    for (int i = 0; i < c_DEPTH; i++) begin
      step(0, 1, 3'd4, 16'h0, "nest_ret");
      chk("nest_ret_order", 32'(OUT), 32'(ret_addrs.pop_back()));
    end

    // Underflow after reset, error stays sticky across JUMP, rst clears
    step(1, 1, 3'd0, 16'h0, "rst2");
    step(0, 1, 3'd4, 16'h0, "underflow");
    chk("underflow_OUT", 32'(OUT), 32'(c_RV));
    step(0, 1, 3'd1, 16'h0040, "jmp40_err");
    step(1, 0, 3'd0, 16'h0, "rst_clear");

    // Reset during a CALL wins; stale entries must not come back
    step(0, 1, 3'd3, 16'h0300, "call_pre");
    step(1, 1, 3'd3, 16'h0400, "rst_call");
    step(0, 1, 3'd4, 16'h0, "ret_after_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'd6 && $urandom_range(0, 1) == 0) rop = 3'd3;
      if (rop == 3'd7 && $urandom_range(0, 1) == 0) rop = 3'd4;
      rin = ($urandom_range(0, 1) == 0) ? 16'($signed(7'($urandom))) : 16'($urandom);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0), rop, rin, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, program address width in bits (min 4).
REQ-002 SHALL have parameter STACK_DEPTH, default 8, number of return-address entries (min 1).
REQ-003 SHALL have parameter RESET_VECTOR, default 0, OUT value after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port CE  input  1  step enable; when low, all state holds.
REQ-007 SHALL have port op  input  3  operation select, sampled when CE high.
REQ-008 SHALL have port IN  input  WIDTH  jump/call target, or two's-complement branch offset.
REQ-009 SHALL have port OUT  output  WIDTH  registered current program address.
REQ-010 SHALL have port stack_full  output  1  high when occupancy equals STACK_DEPTH.
REQ-011 SHALL have port stack_empty  output  1  high when occupancy is 0.
REQ-012 SHALL have port error  output  1  sticky flag for stack overflow or underflow.

Function
REQ-013 SHALL update OUT, stack and error only on a rising clk edge with rst low and CE high.
REQ-014 SHALL, for op=000 (INC), set OUT to OUT+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-015 SHALL, for op=001 (JUMP), set OUT to IN.
REQ-016 SHALL, for op=010 (BRANCH), set OUT to OUT+IN modulo 2^WIDTH, with IN treated as signed.
REQ-017 SHALL, for op=011 (CALL) when not full, push OUT+1 (mod 2^WIDTH), increment occupancy and set OUT to IN.
REQ-018 SHALL, for op=011 when stack_full, leave OUT and the stack unchanged and set error.
REQ-019 SHALL, for op=100 (RET) when not empty, set OUT to the top entry and decrement occupancy.
REQ-020 SHALL, for op=100 when stack_empty, leave OUT and the stack unchanged and set error.
REQ-021 SHALL, for op=101 (HOLD) and reserved ops 110/111, leave all state unchanged without setting error.
REQ-022 SHALL make the stack LIFO: the most recently pushed, not yet popped entry returns first.
REQ-023 SHALL make OUT reflect the new address in the cycle after the controlling edge (one-cycle latency, no combinational path from IN/op to OUT).
REQ-024 SHALL derive stack_full and stack_empty from registered occupancy only, valid in the same cycle as OUT.
REQ-025 SHALL keep error set once set, until rst.
REQ-026 SHALL track occupancy over range 0..STACK_DEPTH inclusive, with the counter wide enough to hold STACK_DEPTH.
REQ-027 SHALL treat op as don't-care when CE is low.

Reset
REQ-028 SHALL, on a rising edge with rst high, set OUT=RESET_VECTOR, occupancy=0, stack_empty=1, stack_full=0 and error=0, regardless of CE and op.
REQ-029 SHALL give rst priority over any in-progress CALL/RET; the stack contents after reset are don't-care and must never be returned.
REQ-030 SHALL assert each output to its reset value in the cycle after the first reset edge.

Verification
REQ-031 SHALL cover sequence: reset, CE=1, op=INC for 3 cycles -> OUT 0,1,2,3; then CE=0 for 2 cycles -> OUT holds at 3.
REQ-032 SHALL cover: OUT=0x0010, BRANCH IN=0xFFFE -> OUT=0x000E; OUT=0xFFFF, INC -> OUT=0x0000 with error=0.
REQ-033 SHALL cover: OUT=0x0005, CALL IN=0x0100 -> OUT=0x0100, stack_empty=0; then RET -> OUT=0x0006, stack_empty=1.
REQ-034 SHALL cover, with STACK_DEPTH=8: 8 nested CALLs -> stack_full=1; a 9th CALL -> OUT unchanged and error=1; 8 RETs -> return addresses in reverse order.
REQ-035 SHALL cover: reset, then RET -> OUT=RESET_VECTOR and error=1; a JUMP IN=0x0040 -> OUT=0x0040 with error still 1; rst -> error=0.
REQ-036 SHALL cover: rst asserted in the same cycle as a CALL with CE=1 -> OUT=RESET_VECTOR and stack_empty=1 on the next cycle.
